// File: rtl/display_scan_ctrl.sv
// Browse controller for the register-file / data-memory debug display.
// Conditions raw buttons and the auto switch into a registered view select, address and step strobe.
module display_scan_ctrl #(
    parameter int DB_CYCLES   = 1000000,
    parameter int SCAN_CYCLES = 100000000,
    parameter int REG_DEPTH   = 32,
    parameter int MEM_DEPTH   = 64
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_mode,
    input  logic       auto_en,
    output logic       show_mem,
    output logic [5:0] addr,
    output logic       step_pulse,
    output logic       auto_active
);

    localparam int DCW = $clog2(DB_CYCLES + 1);
    localparam int TCW = $clog2(SCAN_CYCLES + 1);
    localparam logic [DCW-1:0] DB_LAST   = DCW'(DB_CYCLES - 1);
    localparam logic [TCW-1:0] SCAN_LAST = TCW'(SCAN_CYCLES - 1);
    localparam logic [5:0]     REG_LAST  = 6'(REG_DEPTH - 1);
    localparam logic [5:0]     MEM_LAST  = 6'(MEM_DEPTH - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    // Bit order: {auto_en, btn_mode, btn_prev, btn_next}
    logic [3:0]     sync1, sync2;
    logic [2:0]     db_level, db_prev;
    logic [DCW-1:0] db_cnt [3];
    logic [2:0]     press;
    logic           auto_sync;

    state_t         state, state_next;
    logic [TCW-1:0] timer, timer_n;
    logic           show_mem_n, step_n;
    logic [5:0]     addr_n, last, addr_inc, addr_dec;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {auto_en, btn_mode, btn_prev, btn_next};
            sync2 <= sync1;
        end
    end

    // A level is accepted only after it differs from the current one for DB_CYCLES straight cycles.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            db_level <= '0;
            db_prev  <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            db_prev <= db_level;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DCW'(1);
                end
            end
        end
    end

    assign press     = db_level & ~db_prev;
    assign auto_sync = sync2[3];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= MANUAL;
        else      state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            MANUAL: if (auto_sync)  state_next = AUTO;
            AUTO:   if (!auto_sync) state_next = MANUAL;
            default: state_next = MANUAL;
        endcase
    end

    assign last     = show_mem ? MEM_LAST : REG_LAST;
    assign addr_inc = (addr == last) ? 6'd0 : addr + 6'd1;
    assign addr_dec = (addr == 6'd0) ? last : addr - 6'd1;

    always_comb begin
        show_mem_n = show_mem;
        addr_n     = addr;
        timer_n    = timer;
        if (press[2]) begin
            show_mem_n = ~show_mem;
            addr_n     = 6'd0;
            timer_n    = '0;
        end else if (state == AUTO) begin
            // Step presses are dropped here rather than queued.
            if (timer == SCAN_LAST) begin
                addr_n  = addr_inc;
                timer_n = '0;
            end else begin
                timer_n = timer + TCW'(1);
            end
        end else if (press[0] && press[1]) begin
            addr_n = addr;
        end else if (press[0]) begin
            addr_n = addr_inc;
        end else if (press[1]) begin
            addr_n = addr_dec;
        end
        if (state_next != state) timer_n = '0;
        step_n = (show_mem_n != show_mem) || (addr_n != addr);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            timer       <= '0;
            show_mem    <= 1'b0;
            addr        <= 6'd0;
            step_pulse  <= 1'b0;
            auto_active <= 1'b0;
        end else begin
            timer       <= timer_n;
            show_mem    <= show_mem_n;
            addr        <= addr_n;
            step_pulse  <= step_n;
            auto_active <= (state_next == AUTO);
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with short debounce and scan periods.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_display_scan_ctrl;

    localparam int DB   = 4;
    localparam int SCAN = 8;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       btn_next = 1'b0, btn_prev = 1'b0, btn_mode = 1'b0, auto_en = 1'b0;
    logic       show_mem;
    logic [5:0] addr;
    logic       step_pulse, auto_active;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .DB_CYCLES(DB), .SCAN_CYCLES(SCAN), .REG_DEPTH(32), .MEM_DEPTH(64)
    ) dut (
        .clk(clk), .clr(clr),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_mode(btn_mode), .auto_en(auto_en),
        .show_mem(show_mem), .addr(addr), .step_pulse(step_pulse), .auto_active(auto_active)
    );

    typedef struct {
        string      name;
        logic       nx;
        logic       pv;
        logic       md;
        logic       exp_show;
        logic [5:0] exp_addr;
        int         exp_pulses;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic press_btns(input logic nx, input logic pv, input logic md, output int pulses);
        pulses   = 0;
        btn_next = nx;
        btn_prev = pv;
        btn_mode = md;
        repeat (12) begin
            @(negedge clk);
            pulses += int'(step_pulse);
        end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        btn_mode = 1'b0;
        repeat (10) begin
            @(negedge clk);
            pulses += int'(step_pulse);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses;
        int steps;
        int exp_addr;
        int last_c;

        vecs[0] = '{"reg_prev_wrap",  1'b0, 1'b1, 1'b0, 1'b0, 6'd31, 1};
        vecs[1] = '{"reg_next_wrap",  1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1};
        vecs[2] = '{"reg_both",       1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  0};
        vecs[3] = '{"mode_to_mem",    1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  1};
        vecs[4] = '{"mem_prev_wrap",  1'b0, 1'b1, 1'b0, 1'b1, 6'd63, 1};
        vecs[5] = '{"mem_next_wrap",  1'b1, 1'b0, 1'b0, 1'b1, 6'd0,  1};
        vecs[6] = '{"mem_next",       1'b1, 1'b0, 1'b0, 1'b1, 6'd1,  1};
        vecs[7] = '{"mem_both",       1'b1, 1'b1, 1'b0, 1'b1, 6'd1,  0};
        vecs[8] = '{"mode_to_reg",    1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1};
        vecs[9] = '{"reg_prev_again", 1'b0, 1'b1, 1'b0, 1'b0, 6'd31, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_show_mem", show_mem, 0);
        check("rst_addr", addr, 0);
        check("rst_step", step_pulse, 0);
        check("rst_auto", auto_active, 0);
        clr = 1'b1;

        // Press latency: raw edge to new address takes DB+3 = 7 edges
        btn_next = 1'b1;
        pulses   = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            pulses += int'(step_pulse);
            if (k == 6) check("lat_addr_before", addr, 0);
            if (k == 7) begin
                check("lat_addr_at7", addr, 1);
                check("lat_step_at7", step_pulse, 1);
            end
            if (k == 8) check("lat_step_after", step_pulse, 0);
        end
        check("lat_pulse_count", pulses, 1);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        check("release_no_change", addr, 1);

        // Bounce: toggling every 2 cycles never survives the debounce window
        do_reset();
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            btn_next = ((k / 2) % 2) == 0;
            @(negedge clk);
            pulses += int'(step_pulse);
        end
        btn_next = 1'b1;
        repeat (15) begin
            @(negedge clk);
            pulses += int'(step_pulse);
        end
        btn_next = 1'b0;
        repeat (10) begin
            @(negedge clk);
            pulses += int'(step_pulse);
        end
        check("bounce_pulses", pulses, 1);
        check("bounce_addr", addr, 1);

        // Manual stepping, wrap and view-toggle table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            press_btns(vecs[i].nx, vecs[i].pv, vecs[i].md, pulses);
            check({vecs[i].name, "_show"}, show_mem, vecs[i].exp_show);
            check({vecs[i].name, "_addr"}, addr, vecs[i].exp_addr);
            check({vecs[i].name, "_pulses"}, pulses, vecs[i].exp_pulses);
        end

        // Auto-scan: entry after 3 edges, one advance every 8 cycles, presses ignored
        do_reset();
        auto_en  = 1'b1;
        steps    = 0;
        exp_addr = 0;
        for (int c = 1; c <= 360; c++) begin
            @(negedge clk);
            if (c == 2) check("auto_active_early", auto_active, 0);
            if (c == 3) check("auto_active_on", auto_active, 1);
            if (step_pulse) begin
                steps++;
                exp_addr = (exp_addr + 1) % 32;
                check("auto_addr", addr, exp_addr);
                check("auto_cycle", c, 3 + SCAN * steps);
            end
            if (steps == 40) break;
            if (c == 265) btn_next = 1'b1;
            if (c == 281) btn_next = 1'b0;
            if (c == 290) btn_prev = 1'b1;
            if (c == 306) btn_prev = 1'b0;
        end
        check("auto_step_count", steps, 40);
        auto_en = 1'b0;
        pulses  = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            pulses += int'(step_pulse);
            if (k == 3) check("auto_active_off", auto_active, 0);
        end
        check("frozen_pulses", pulses, 0);
        check("frozen_addr", addr, 8);

        // Mode press landing on the auto terminal count
        do_reset();
        auto_en = 1'b1;
        pulses  = 0;
        last_c  = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            last_c = c;
            if (c == 11) begin
                check("mode_tc_show", show_mem, 1);
                check("mode_tc_addr", addr, 0);
                check("mode_tc_step", step_pulse, 1);
            end
            if (c >= 12 && c <= 18) pulses += int'(step_pulse);
            if (c == 19) begin
                check("timer_restart_pulses", pulses, 0);
                check("timer_restart_step", step_pulse, 1);
                check("timer_restart_addr", addr, 1);
            end
            if (c == 147) break;
            if (c == 4)  btn_mode = 1'b1;
            if (c == 15) btn_mode = 1'b0;
        end
        check("reach_cycle", last_c, 147);
        check("reach_addr17", addr, 17);
        check("reach_show", show_mem, 1);

        // Mid-operation reset with btn_mode held through it
        btn_mode = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("midrst_show", show_mem, 0);
        check("midrst_addr", addr, 0);
        check("midrst_step", step_pulse, 0);
        check("midrst_auto", auto_active, 0);
        @(negedge clk);
        clr = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) check("midrst_auto_back", auto_active, 1);
            if (k == 6) check("midrst_show_before", show_mem, 0);
            if (k == 7) begin
                check("midrst_show_at7", show_mem, 1);
                check("midrst_addr_at7", addr, 0);
            end
        end
        check("midrst_single_press", show_mem, 1);
        btn_mode = 1'b0;
        auto_en  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
